xff_flex: RTL and testbench

Parametrised synchronous FIFO that succeeds the power-of-two-only FIFO. It supports any depth of 2 or more and two read modes: registered-read and first-word-fall-through (FWFT). It also provides an occupancy count, programmable almost-full/almost-empty flags, a synchronous flush, and sticky overflow/underflow error flags. It sits between switch-port pipeline stages and in front of arbiters that need early back-pressure.

---
 rtl/xff_pkg.sv | 18 +
 rtl/xff_flex_mem.sv | 25 ++
 rtl/xff_flex.sv | 131 +++++++++++++
 tb/tb_xff_flex.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/xff_pkg.sv
// rtl/xff_pkg.sv - shared types and sizing helpers for the flexible-depth FIFO
package xff_pkg;

  typedef enum logic {
    XFF_REGREAD = 1'b0,
    XFF_FWFT    = 1'b1
  } xff_rmode_e;

  function automatic int xff_lw(input int depth);
    return $clog2(depth + 1);
  endfunction

  // A two-entry FIFO still needs one pointer bit.
  function automatic int xff_aw(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/xff_flex_mem.sv
// rtl/xff_flex_mem.sv - DW x DEPTH dual-port RAM, synchronous write, combinational read
module xff_flex_mem #(
  parameter int DW    = 8,
  parameter int DEPTH = 5,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/xff_flex.sv
// rtl/xff_flex.sv - any-depth synchronous FIFO with FWFT/registered read, level and sticky error flags
module xff_flex
  import xff_pkg::*;
#(
  parameter int DW        = 8,
  parameter int DEPTH     = 5,
  parameter int FWFT      = 1,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1,
  localparam int LW       = xff_lw(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          we,
  input  logic          re,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q,
  output logic          full_n,
  output logic          empty_n,
  output logic [LW-1:0] level,
  output logic          afull,
  output logic          aempty,
  output logic          ovf,
  output logic          udf
);

  localparam int AW = xff_aw(DEPTH);
  localparam xff_rmode_e RMODE = (FWFT != 0) ? XFF_FWFT : XFF_REGREAD;
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_AF   = LW'(AFULL_TH);
  localparam logic [LW-1:0] LVL_AE   = LW'(AEMPTY_TH);

  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          full_n_q, empty_n_q, afull_q, aempty_q, ovf_q, udf_q;
  logic          ovf_d, udf_d;
  logic          wr_acc, rd_acc;
  logic [DW-1:0] rd_data;

  assign wr_acc = we && full_n_q && !clr;
  assign rd_acc = re && empty_n_q && !clr;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q | (we && !full_n_q);
    udf_d   = udf_q | (re && !empty_n_q);
    if (clr) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      // Explicit wrap keeps non-power-of-two depths inside the array.
      if (wr_acc) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
      if (rd_acc) rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      level_q   <= '0;
      full_n_q  <= 1'b1;
      empty_n_q <= 1'b0;
      afull_q   <= ('0 >= LVL_AF);
      aempty_q  <= 1'b1;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      level_q   <= level_d;
      // Flags come from level_d so they line up with level every cycle.
      full_n_q  <= (level_d != LVL_FULL);
      empty_n_q <= (level_d != '0);
      afull_q   <= (level_d >= LVL_AF);
      aempty_q  <= (level_d <= LVL_AE);
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  xff_flex_mem #(
    .DW   (DW),
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk    (clk),
    .wr_en  (wr_acc),
    .wr_addr(wptr_q),
    .wr_data(d),
    .rd_addr(rptr_q),
    .rd_data(rd_data)
  );

  generate
    if (RMODE == XFF_FWFT) begin : g_fwft
      assign q = rd_data;
    end else begin : g_regread
      logic [DW-1:0] q_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          q_q <= '0;
        end else if (rd_acc) begin
          q_q <= rd_data;
        end
      end
      assign q = q_q;
    end
  endgenerate

  assign level   = level_q;
  assign full_n  = full_n_q;
  assign empty_n = empty_n_q;
  assign afull   = afull_q;
  assign aempty  = aempty_q;
  assign ovf     = ovf_q;
  assign udf     = udf_q;

endmodule

// File: tb/tb_xff_flex.sv
// tb/tb_xff_flex.sv - directed scoreboard bench for xff_flex in FWFT and registered-read modes
module tb_xff_flex;

  logic       clk = 1'b0;
  logic       rstn;
  logic       clr_f, we_f, re_f;
  logic [7:0] d_f, q_f;
  logic       full_n_f, empty_n_f, afull_f, aempty_f, ovf_f, udf_f;
  logic [2:0] level_f;
  logic       clr_r, we_r, re_r;
  logic [7:0] d_r, q_r;
  logic       full_n_r, empty_n_r, afull_r, aempty_r, ovf_r, udf_r;
  logic [2:0] level_r;

  int total = 0;
  int bad   = 0;
  int mlevel;
  logic movf, mudf;
  logic [7:0] sb_f[$];
  logic [7:0] sb_r[$];
  logic [7:0] exp_b;

  always #5 clk = ~clk;

  xff_flex #(.DW(8), .DEPTH(5), .FWFT(1), .AFULL_TH(4), .AEMPTY_TH(1)) u_fw (
    .clk(clk), .rstn(rstn), .clr(clr_f), .we(we_f), .re(re_f), .d(d_f), .q(q_f),
    .full_n(full_n_f), .empty_n(empty_n_f), .level(level_f), .afull(afull_f),
    .aempty(aempty_f), .ovf(ovf_f), .udf(udf_f)
  );

  xff_flex #(.DW(8), .DEPTH(5), .FWFT(0), .AFULL_TH(4), .AEMPTY_TH(1)) u_rr (
    .clk(clk), .rstn(rstn), .clr(clr_r), .we(we_r), .re(re_r), .d(d_r), .q(q_r),
    .full_n(full_n_r), .empty_n(empty_n_r), .level(level_r), .afull(afull_r),
    .aempty(aempty_r), .ovf(ovf_r), .udf(udf_r)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_fw_flags(input string tag);
    check({tag, ".level"},   32'(level_f),   32'(mlevel));
    check({tag, ".full_n"},  32'(full_n_f),  32'(mlevel != 5));
    check({tag, ".empty_n"}, 32'(empty_n_f), 32'(mlevel != 0));
    check({tag, ".afull"},   32'(afull_f),   32'(mlevel >= 4));
    check({tag, ".aempty"},  32'(aempty_f),  32'(mlevel <= 1));
    check({tag, ".ovf"},     32'(ovf_f),     32'(movf));
    check({tag, ".udf"},     32'(udf_f),     32'(mudf));
  endtask

  // One clock of FWFT stimulus; the model predicts acceptance from its own level.
  task automatic cyc(input string tag, input logic w, input logic r, input logic [7:0] din,
                     input logic c);
    logic wa, ra;
    we_f = w; re_f = r; d_f = din; clr_f = c;
    wa = w && (mlevel != 5) && !c;
    ra = r && (mlevel != 0) && !c;
    #1;
    if (ra) begin
      if (sb_f.size() == 0) check({tag, ".sb_empty"}, 32'd1, 32'd0);
      else begin
        exp_b = sb_f.pop_front();
        check({tag, ".q"}, 32'(q_f), 32'(exp_b));
      end
    end
    if (wa) sb_f.push_back(din);
    if (c) begin
      movf = 1'b0; mudf = 1'b0; mlevel = 0; sb_f.delete();
    end else begin
      movf = movf | (w && mlevel == 5);
      mudf = mudf | (r && mlevel == 0);
      mlevel = mlevel + int'(wa) - int'(ra);
    end
    @(posedge clk); #1;
    we_f = 1'b0; re_f = 1'b0; clr_f = 1'b0;
    check_fw_flags(tag);
  endtask

  initial begin
    rstn = 1'b0;
    {clr_f, we_f, re_f, d_f} = '0;
    {clr_r, we_r, re_r, d_r} = '0;
    mlevel = 0; movf = 1'b0; mudf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_fw_flags("reset");
    check("reset.rr_q", 32'(q_r), 32'h0);
    check("reset.rr_level", 32'(level_r), 32'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_fw_flags("idle");

    for (int i = 0; i < 5; i++) cyc("fill", 1'b1, 1'b0, 8'h11 * (i + 1), 1'b0);
    for (int i = 0; i < 5; i++) cyc("drain", 1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 3; i++) cyc("pre_w", 1'b1, 1'b0, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 3; i++) cyc("pre_r", 1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) cyc("wrap_w", 1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) cyc("wrap_r", 1'b0, 1'b1, 8'h00, 1'b0);

    for (int i = 0; i < 5; i++) cyc("ovf_fill", 1'b1, 1'b0, 8'h60 + 8'(i), 1'b0);
    cyc("ovf_both", 1'b1, 1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 4; i++) cyc("ovf_drain", 1'b0, 1'b1, 8'h00, 1'b0);

    cyc("udf_read", 1'b0, 1'b1, 8'h00, 1'b0);
    cyc("clr_we", 1'b1, 1'b0, 8'h77, 1'b1);
    cyc("empty_both", 1'b1, 1'b1, 8'h88, 1'b0);
    for (int i = 0; i < 4; i++) cyc("stream", 1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
    cyc("stream_end", 1'b0, 1'b1, 8'h00, 1'b0);

    we_r = 1'b1; d_r = 8'h3C;
    sb_r.push_back(8'h3C);
    @(posedge clk); #1;
    we_r = 1'b0;
    check("rr.empty_n", 32'(empty_n_r), 32'h1);
    check("rr.q_before", 32'(q_r), 32'h0);
    re_r = 1'b1;
    @(posedge clk); #1;
    re_r = 1'b0;
    exp_b = sb_r.pop_front();
    check("rr.q_read", 32'(q_r), 32'(exp_b));
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("rr.q_hold", 32'(q_r), 32'(exp_b));
    end
    re_r = 1'b1;
    @(posedge clk); #1;
    re_r = 1'b0;
    check("rr.q_rejected", 32'(q_r), 32'(exp_b));
    check("rr.udf", 32'(udf_r), 32'h1);
    clr_r = 1'b1;
    @(posedge clk); #1;
    clr_r = 1'b0;
    check("rr.q_clr", 32'(q_r), 32'(exp_b));
    check("rr.udf_clr", 32'(udf_r), 32'h0);

    cyc("pre_rst", 1'b1, 1'b0, 8'h91, 1'b0);
    cyc("pre_rst", 1'b1, 1'b0, 8'h92, 1'b0);
    #2;
    rstn = 1'b0;
    #1;
    mlevel = 0; movf = 1'b0; mudf = 1'b0; sb_f.delete();
    check_fw_flags("async_rst");
    check("async_rst.rr_q", 32'(q_r), 32'h0);
    @(posedge clk); #1;
    rstn = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
